// File: rtl/float_pkg.sv
// ---------------------------------------------------------------------------
// float_pkg : shared bf16 field widths, bias, limits and adder state encoding
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package float_pkg;

  localparam int BF16_W     = 16;
  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int BF16_BIAS  = 127;

  localparam logic [BF16_EXP_W-1:0]            BF16_EXP_MAX_FINITE = 8'hFE;
  localparam logic [BF16_MAN_W-1:0]            BF16_MAN_MAX        = 7'h7F;
  localparam logic [BF16_EXP_W+BF16_MAN_W-1:0] BF16_MAX_FINITE_MAG =
    {BF16_EXP_MAX_FINITE, BF16_MAN_MAX};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } adder_state_e;

endpackage

`default_nettype wire

// File: rtl/bf16_unpack.sv
// ---------------------------------------------------------------------------
// bf16_unpack : split a bf16 word into sign, exponent, hidden-bit mantissa
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bf16_unpack
  import float_pkg::*;
(
  input  logic [BF16_W-1:0]     word_i,
  output logic                  sign_o,
  output logic [BF16_EXP_W-1:0] exp_o,
  output logic [BF16_MAN_W:0]   man_o,
  output logic                  zero_o
);

  assign sign_o = word_i[BF16_W-1];
  assign exp_o  = word_i[BF16_W-2:BF16_MAN_W];
  // Zero exponent means zero: subnormals are not represented.
  assign zero_o = (word_i[BF16_W-2:BF16_MAN_W] == '0);
  assign man_o  = zero_o ? '0 : {1'b1, word_i[BF16_MAN_W-1:0]};

endmodule

`default_nettype wire

// File: rtl/float_adder_bf16.sv
// ---------------------------------------------------------------------------
// float_adder_bf16 : iterative bf16 adder, 1-bit/cycle align and normalise.
// Build option     : FLOAT_ADDER_RNE_EN selects round-nearest-even, else truncate
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module float_adder_bf16
  import float_pkg::*;
#(
  parameter int MAX_ALIGN = 11
)
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] y,
  output logic        out_valid
);

  localparam logic [7:0] ALIGN_CAP = 8'(MAX_ALIGN);

  adder_state_e state_q, state_d;
  logic         sign_q, sign_d;
  logic         sub_q, sub_d;
  logic [8:0]   exp_q, exp_d;
  logic [10:0]  big_m_q, big_m_d;
  logic [10:0]  small_m_q, small_m_d;
  logic [11:0]  sum_q, sum_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [15:0]  y_q, y_d;

  logic       w_a_sign, w_b_sign, w_a_zero, w_b_zero, w_a_big;
  logic [7:0] w_a_exp, w_b_exp, w_a_man, w_b_man;
  logic [7:0] w_ediff, w_dsat;

  bf16_unpack u_unpack_a (
    .word_i (a),
    .sign_o (w_a_sign),
    .exp_o  (w_a_exp),
    .man_o  (w_a_man),
    .zero_o (w_a_zero)
  );

  bf16_unpack u_unpack_b (
    .word_i (b),
    .sign_o (w_b_sign),
    .exp_o  (w_b_exp),
    .man_o  (w_b_man),
    .zero_o (w_b_zero)
  );

  assign w_a_big = w_b_zero || (!w_a_zero && (a[14:0] >= b[14:0]));
  assign w_ediff = w_a_big ? (w_a_exp - w_b_exp) : (w_b_exp - w_a_exp);
  assign w_dsat  = (w_ediff > ALIGN_CAP) ? ALIGN_CAP : w_ediff;

  logic       w_round_up;
  logic [8:0] w_man_rnd;
  logic [9:0] w_exp_rnd;
  logic       w_res_zero;

`ifdef FLOAT_ADDER_RNE_EN
  assign w_round_up = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
`else
  assign w_round_up = 1'b0;
`endif

  // Rounding overflow lands on 1.0000000 with bit 8 set; the fraction bits are then 0.
  assign w_man_rnd  = {1'b0, sum_q[10:3]} + {8'd0, w_round_up};
  assign w_exp_rnd  = {1'b0, exp_q} + {9'd0, w_man_rnd[8]};
  assign w_res_zero = (exp_q == 9'd0) || (w_man_rnd[8:7] == 2'b00);

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    sub_d     = sub_q;
    exp_d     = exp_q;
    big_m_d   = big_m_q;
    small_m_d = small_m_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    y_d       = y_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = ALIGN;
          sign_d    = w_a_big ? w_a_sign : w_b_sign;
          sub_d     = w_a_sign ^ w_b_sign;
          exp_d     = {1'b0, (w_a_big ? w_a_exp : w_b_exp)};
          big_m_d   = {(w_a_big ? w_a_man : w_b_man), 3'b000};
          small_m_d = {(w_a_big ? w_b_man : w_a_man), 3'b000};
          cnt_d     = w_dsat;
        end
      end

      ALIGN: begin
        if (cnt_q == 8'd0) begin
          state_d = ADD;
        end else begin
          // Bit 0 is the sticky position and keeps everything shifted past it.
          small_m_d = {1'b0, small_m_q[10:2], small_m_q[1] | small_m_q[0]};
          cnt_d     = cnt_q - 8'd1;
        end
      end

      ADD: begin
        state_d = NORM;
        sum_d   = sub_q ? ({1'b0, big_m_q} - {1'b0, small_m_q})
                        : ({1'b0, big_m_q} + {1'b0, small_m_q});
      end

      NORM: begin
        if (sum_q == 12'd0) begin
          sum_d   = 12'd0;
          exp_d   = 9'd0;
          sign_d  = 1'b0;
          state_d = ROUND;
        end else if (sum_q[11]) begin
          sum_d   = {1'b0, sum_q[11:2], sum_q[1] | sum_q[0]};
          exp_d   = exp_q + 9'd1;
          state_d = ROUND;
        end else if (sum_q[10]) begin
          state_d = ROUND;
        end else if (exp_q <= 9'd1) begin
          sum_d   = 12'd0;
          exp_d   = 9'd0;
          state_d = ROUND;
        end else begin
          sum_d = {sum_q[10:0], 1'b0};
          exp_d = exp_q - 9'd1;
        end
      end

      ROUND: begin
        state_d = DONE;
        if (w_res_zero) begin
          y_d = {sign_q, 15'd0};
        end else if (w_exp_rnd >= 10'd255) begin
          y_d = {sign_q, BF16_MAX_FINITE_MAG};
        end else begin
          y_d = {sign_q, w_exp_rnd[7:0], w_man_rnd[6:0]};
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      sub_q     <= 1'b0;
      exp_q     <= 9'd0;
      big_m_q   <= 11'd0;
      small_m_q <= 11'd0;
      sum_q     <= 12'd0;
      cnt_q     <= 8'd0;
      y_q       <= 16'h0000;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      sub_q     <= sub_d;
      exp_q     <= exp_d;
      big_m_q   <= big_m_d;
      small_m_q <= small_m_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;

endmodule

`default_nettype wire
